// File: rtl/spy_buffer_pkg.sv
// Shared definitions for the spy-buffer blocks: playback state encoding and
// default memory geometry.
package spy_buffer_pkg;

  localparam int SPY_WIDTH_DEF     = 6;
  localparam int SPY_DATAWIDTH_DEF = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARM   = ST_ARM,
    READ  = ST_READ,
    DRAIN = ST_DRAIN
  } pb_state_e;

endpackage

// File: rtl/spy_playback_fifo.sv
// Output FIFO for the playback engine. First-word-fall-through: the head entry
// is presented on pop_data whenever valid is high. pop_data reads 0 when empty.
// Ports:
//   clock, reset      clock and async active-low reset
//   push, push_data   write port (ignored when full)
//   pop               consume head entry (ignored when empty)
//   pop_data, valid   head entry and non-empty flag
//   count             number of stored entries
module spy_playback_fifo
  import spy_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 65,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible after it has been pushed.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign valid    = (count_q != '0);
  assign pop_data = valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/spy_playback.sv
// Readout engine for the spy-buffer circular memory. On playback_start it
// freezes the memory, snapshots the write pointer and wrap state, and streams
// the stored words oldest-first on a valid/ready port, marking the final word.
// Ports:
//   clock, reset                      clock and async active-low reset
//   playback_start                    request, honoured in IDLE only
//   spy_write_enable/pointer          memory write strobe and pointer (wrap tracking)
//   spy_read_addr/enable/data         memory read port, data one cycle after strobe
//   freeze                            gates memory writes while busy
//   out_data/valid/last/ready         streamed words
//   busy, done                        engine active / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for playback_start
// ARM   | writes frozen; snapshot start address and word count
// READ  | issuing memory reads while the FIFO has room
// DRAIN | all reads issued; waiting for the last word to be accepted
module spy_playback
  import spy_buffer_pkg::*;
#(
  parameter int WIDTH     = SPY_WIDTH_DEF,
  parameter int DATAWIDTH = SPY_DATAWIDTH_DEF,
  parameter int OUT_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 playback_start,
  input  logic                 spy_write_enable,
  input  logic [WIDTH-1:0]     spy_write_pointer,
  output logic [WIDTH-1:0]     spy_read_addr,
  output logic                 spy_read_enable,
  input  logic [DATAWIDTH-1:0] spy_read_data,
  output logic                 freeze,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int SIZE = 1 << WIDTH;
  localparam int NW   = WIDTH + 1;
  localparam int CW   = $clog2(OUT_DEPTH + 1);
  localparam int OW   = CW + 1;

  pb_state_e        state_q, state_d;
  logic             wrapped_q;
  logic [WIDTH-1:0] start_q, last_addr_q;
  logic [NW-1:0]    count_q, idx_q;
  logic [1:0]       inflight_q;
  logic             pend_q, pend_last_q;
  logic             done_q, done_d;

  logic [WIDTH-1:0] snap_start, issue_addr;
  logic [NW-1:0]    snap_count;
  logic             idx_last, room, issue;
  logic [CW-1:0]    fifo_count;
  logic [OW-1:0]    occupancy;
  logic             fifo_valid, fifo_pop;
  logic [DATAWIDTH:0] fifo_head;

  assign snap_start = wrapped_q ? spy_write_pointer : '0;
  assign snap_count = wrapped_q ? NW'(SIZE) : {1'b0, spy_write_pointer};
  assign idx_last   = (idx_q == count_q - NW'(1));
  assign issue_addr = start_q + idx_q[WIDTH-1:0];

  // Reads in flight still need a FIFO slot, so reserve them before issuing.
  assign occupancy  = {1'b0, fifo_count} + OW'(inflight_q);
  assign room       = (occupancy < OW'(OUT_DEPTH));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE:  if (playback_start) state_d = ARM;
      ARM: begin
        if (snap_count == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        if (room) begin
          issue = 1'b1;
          if (idx_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && fifo_head[DATAWIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wrapped_q   <= 1'b0;
      start_q     <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      last_addr_q <= '0;
      inflight_q  <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (spy_write_enable && (spy_write_pointer == WIDTH'(SIZE - 1))) wrapped_q <= 1'b1;
      if (state_q == ARM) begin
        start_q <= snap_start;
        count_q <= snap_count;
        idx_q   <= '0;
      end
      if (issue) begin
        idx_q       <= idx_q + NW'(1);
        last_addr_q <= issue_addr;
      end
      // pend_q marks the cycle in which the memory returns an issued read.
      pend_q      <= issue;
      pend_last_q <= issue && idx_last;
      case ({issue, pend_q})
        2'b10:   inflight_q <= inflight_q + 2'd1;
        2'b01:   inflight_q <= inflight_q - 2'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  spy_playback_fifo #(
    .DEPTH (OUT_DEPTH),
    .DW    (DATAWIDTH + 1),
    .CW    (CW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pend_q),
    .push_data ({pend_last_q, spy_read_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign fifo_pop        = fifo_valid && out_ready;
  assign out_valid       = fifo_valid;
  assign out_data        = fifo_head[DATAWIDTH-1:0];
  assign out_last        = fifo_head[DATAWIDTH];
  assign spy_read_enable = issue;
  assign spy_read_addr   = issue ? issue_addr : last_addr_q;
  assign busy            = (state_q != IDLE);
  assign freeze          = busy;
  assign done            = done_q;

endmodule
